// File: rtl/display_mux.sv
// Five-digit multiplexed 7-segment driver for the stopwatch display.
// Digits are frozen into a snapshot once per frame so one scan never mixes old and new values.
module display_mux #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK       = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] count,
   input  logic [3:0] dec,
   input  logic [3:0] cent,
   input  logic [3:0] seg,
   input  logic [3:0] seg_dec,
   input  logic       hold,
   output logic [6:0] seg_out,
   output logic       dp,
   output logic [4:0] an,
   output logic       frame_tick
);

   localparam int            CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] DIV_MAX   = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK);

   logic [CW-1:0]   div_cnt_reg;
   logic [2:0]      idx_reg;
   logic [4:0][3:0] snap_reg;
   logic [4:0][3:0] digit_in;

   logic            at_wrap;
   logic            frame_wrap;
   logic            in_blank;
   logic [3:0]      cur_digit;
   logic [6:0]      seg_next;
   logic [4:0]      an_next;
   logic            dp_next;

   logic [6:0]      seg_out_reg;
   logic            dp_reg;
   logic [4:0]      an_reg;
   logic            frame_tick_reg;

   assign digit_in   = {seg_dec, seg, cent, dec, count};
   assign at_wrap    = (div_cnt_reg == DIV_MAX);
   assign frame_wrap = at_wrap && (idx_reg == 3'd4);
   assign in_blank   = (div_cnt_reg < BLANK_END);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt_reg <= '0;
         idx_reg     <= 3'd0;
      end else if (at_wrap) begin
         div_cnt_reg <= '0;
         idx_reg     <= (idx_reg == 3'd4) ? 3'd0 : idx_reg + 3'd1;
      end else begin
         div_cnt_reg <= div_cnt_reg + CW'(1);
      end
   end

   // hold is only looked at on the frame-wrap cycle, so a lap freeze always lands on a frame boundary
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snap_reg <= '0;
      end else if (frame_wrap && !hold) begin
         snap_reg <= digit_in;
      end
   end

   always_comb begin
      cur_digit = snap_reg[0];
      case (idx_reg)
         3'd1:    cur_digit = snap_reg[1];
         3'd2:    cur_digit = snap_reg[2];
         3'd3:    cur_digit = snap_reg[3];
         3'd4:    cur_digit = snap_reg[4];
         default: cur_digit = snap_reg[0];
      endcase

      case (cur_digit)
         4'd0:    seg_next = 7'b1000000;
         4'd1:    seg_next = 7'b1111001;
         4'd2:    seg_next = 7'b0100100;
         4'd3:    seg_next = 7'b0110000;
         4'd4:    seg_next = 7'b0011001;
         4'd5:    seg_next = 7'b0010010;
         4'd6:    seg_next = 7'b0000010;
         4'd7:    seg_next = 7'b1111000;
         4'd8:    seg_next = 7'b0000000;
         4'd9:    seg_next = 7'b0010000;
         default: seg_next = 7'b0111111;
      endcase
      // leftmost digit suppresses a leading zero
      if (idx_reg == 3'd4 && cur_digit == 4'd0) begin
         seg_next = 7'b1111111;
      end

      an_next = 5'b11111;
      if (!in_blank) begin
         an_next = ~(5'b00001 << idx_reg);
      end
      dp_next = !(idx_reg == 3'd3 && !in_blank);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg_out_reg    <= 7'b1111111;
         dp_reg         <= 1'b1;
         an_reg         <= 5'b11111;
         frame_tick_reg <= 1'b0;
      end else begin
         seg_out_reg    <= seg_next;
         dp_reg         <= dp_next;
         an_reg         <= an_next;
         frame_tick_reg <= frame_wrap;
      end
   end

   assign seg_out    = seg_out_reg;
   assign dp         = dp_reg;
   assign an         = an_reg;
   assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_display_mux.sv
// Bench for display_mux: per-cycle scoreboard of expected outputs plus directed slot checks.
module tb_display_mux;

   localparam int RD = 4;
   localparam int BL = 1;
   localparam logic [6:0] DEC_TAB [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
      7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] count = 4'd0, dec = 4'd0, cent = 4'd0, seg = 4'd0, seg_dec = 4'd0;
   logic       hold = 1'b0;
   logic [6:0] seg_out;
   logic       dp;
   logic [4:0] an;
   logic       frame_tick;

   int         n_checks = 0;
   int         n_fail   = 0;

   int         m_div = 0;
   int         m_idx = 0;
   logic [3:0] m_snap [5] = '{default: 4'd0};
   logic [13:0] exp_q [$];

   bit         rand_mode = 1'b0;
   logic [3:0] fix_val [5] = '{default: 4'd0};

   display_mux #(.REFRESH_DIV(RD), .BLANK(BL)) dut (
      .clk(clk), .rst(rst), .count(count), .dec(dec), .cent(cent), .seg(seg),
      .seg_dec(seg_dec), .hold(hold), .seg_out(seg_out), .dp(dp), .an(an),
      .frame_tick(frame_tick));

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] expect_out(input int div, input int idx, input logic [3:0] d);
      logic [6:0] s;
      logic [4:0] a;
      logic       p;
      logic       f;
      s = (idx == 4 && d == 4'd0) ? 7'b1111111 : DEC_TAB[d];
      a = (div < BL) ? 5'b11111 : ~(5'b00001 << idx);
      p = (idx == 3 && div >= BL) ? 1'b0 : 1'b1;
      f = (div == RD - 1 && idx == 4);
      return {s, a, p, f};
   endfunction

   // reference model: expected registered outputs are queued at each edge
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_div <= 0;
         m_idx <= 0;
         for (int i = 0; i < 5; i++) m_snap[i] <= 4'd0;
         exp_q.delete();
      end else begin
         exp_q.push_back(expect_out(m_div, m_idx, m_snap[m_idx]));
         if (m_div == RD - 1) begin
            m_div <= 0;
            m_idx <= (m_idx == 4) ? 0 : m_idx + 1;
            if (m_idx == 4 && !hold) begin
               m_snap[0] <= count;
               m_snap[1] <= dec;
               m_snap[2] <= cent;
               m_snap[3] <= seg;
               m_snap[4] <= seg_dec;
            end
         end else begin
            m_div <= m_div + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst && exp_q.size() > 0) begin
         check_val("sb_seg", seg_out, exp_q[0][13:7]);
         check_val("sb_an", an, exp_q[0][6:2]);
         check_val("sb_dp", dp, exp_q[0][1]);
         check_val("sb_tick", frame_tick, exp_q[0][0]);
         void'(exp_q.pop_front());
      end
   end

   // in random mode inputs churn every cycle except the one the frame wrap samples
   task automatic drive_step();
      if (rand_mode) begin
         if (m_div == RD - 1 && m_idx == 4) begin
            count = fix_val[0]; dec = fix_val[1]; cent = fix_val[2];
            seg = fix_val[3]; seg_dec = fix_val[4];
         end else begin
            count = 4'($urandom_range(0, 15)); dec = 4'($urandom_range(0, 15));
            cent = 4'($urandom_range(0, 15)); seg = 4'($urandom_range(0, 15));
            seg_dec = 4'($urandom_range(0, 15));
         end
      end
   endtask

   task automatic check_slot(input string tag, input int i, input logic [6:0] exp_seg);
      logic [4:0] want;
      bit         seen;
      want = ~(5'b00001 << i);
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         drive_step();
         if (an == want) begin
            seen = 1'b1;
            check_val(tag, seg_out, exp_seg);
            check_val({tag, "_dp"}, dp, (i == 3) ? 1'b0 : 1'b1);
         end
      end
      if (!seen) check_val({tag, "_an_timeout"}, an, want);
   endtask

   task automatic wait_tick(input string tag);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk);
         drive_step();
         if (frame_tick) seen = 1'b1;
      end
      if (!seen) check_val({tag, "_tick_timeout"}, frame_tick, 1'b1);
   endtask

   initial begin
      bit seen;
      repeat (3) @(negedge clk);
      check_val("rst_an", an, 5'b11111);
      check_val("rst_seg", seg_out, 7'b1111111);
      check_val("rst_dp", dp, 1'b1);
      check_val("rst_tick", frame_tick, 1'b0);
      rst = 1'b1;

      // first frame after release shows snapshot zeros, leftmost blanked
      for (int i = 0; i < 4; i++) check_slot($sformatf("zero_d%0d", i), i, 7'b1000000);
      check_slot("zero_d4", 4, 7'b1111111);
      repeat (6) @(negedge clk);

      count = 4'd1; dec = 4'd7; cent = 4'd3; seg = 4'd9; seg_dec = 4'd5; hold = 1'b0;
      wait_tick("load1");
      check_slot("load_d0", 0, 7'b1111001);
      check_slot("load_d1", 1, 7'b1111000);
      check_slot("load_d2", 2, 7'b0110000);
      check_slot("load_d3", 3, 7'b0010000);
      check_slot("load_d4", 4, 7'b0010010);

      hold = 1'b1;
      count = 4'd2; dec = 4'd2; cent = 4'd2; seg = 4'd2; seg_dec = 4'd2;
      wait_tick("hold1");
      check_slot("hold1_d0", 0, 7'b1111001);
      check_slot("hold1_d4", 4, 7'b0010010);
      wait_tick("hold2");
      check_slot("hold2_d0", 0, 7'b1111001);
      hold = 1'b0;
      wait_tick("release");
      check_slot("rel_d0", 0, 7'b0100100);
      check_slot("rel_d4", 4, 7'b0100100);

      count = 4'hC;
      wait_tick("dash");
      check_slot("dash_d0", 0, 7'b0111111);
      check_slot("dash_d1", 1, 7'b0100100);

      fix_val[0] = 4'd3; fix_val[1] = 4'd0; fix_val[2] = 4'd4;
      fix_val[3] = 4'd6; fix_val[4] = 4'd8;
      rand_mode = 1'b1;
      wait_tick("rnd1");
      wait_tick("rnd2");
      check_slot("rnd_d0", 0, 7'b0110000);
      check_slot("rnd_d1", 1, 7'b1000000);
      check_slot("rnd_d2", 2, 7'b0011001);
      check_slot("rnd_d3", 3, 7'b0000010);
      check_slot("rnd_d4", 4, 7'b0000000);
      rand_mode = 1'b0;

      // asynchronous reset in the middle of slot 2
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (m_idx == 2 && m_div == 2) seen = 1'b1;
      end
      check_val("ar_an_pre", an, 5'b11011);
      #2 rst = 1'b0;
      #1;
      check_val("ar_an", an, 5'b11111);
      check_val("ar_seg", seg_out, 7'b1111111);
      check_val("ar_dp", dp, 1'b1);
      check_val("ar_tick", frame_tick, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (an != 5'b11111) begin
            seen = 1'b1;
            check_val("restart_an", an, 5'b11110);
            check_val("restart_seg", seg_out, 7'b1000000);
         end
      end
      if (!seen) check_val("restart_timeout", an, 5'b11110);
      repeat (25) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clock cycles per digit slot; legal range 4 or more.
REQ-002 Parameter BLANK, default 500, cycles at the start of each slot with all anodes off; legal range 1 to REFRESH_DIV-1.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low; the block is in reset while rst is 0.
REQ-005 count  input  4  BCD units digit from the stopwatch counter (digit index 0, rightmost).
REQ-006 dec  input  4  BCD tens digit (index 1).
REQ-007 cent  input  4  BCD hundreds digit (index 2).
REQ-008 seg  input  4  BCD seconds-units digit (index 3).
REQ-009 seg_dec  input  4  BCD seconds-tens digit (index 4, leftmost).
REQ-010 hold  input  1  lap/freeze; while 1, the displayed snapshot is not refreshed.
REQ-011 seg_out  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-012 dp  output  1  active-low decimal point.
REQ-013 an  output  5  active-low anode enables; an[i] drives digit index i.
REQ-014 frame_tick  output  1  one-cycle pulse on each cycle where the snapshot is loaded.

Function
REQ-015 The prescaler div_cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0.
REQ-016 The digit index idx SHALL advance on the div_cnt wrap cycle, sequence 0,1,2,3,4,0,...
REQ-017 On the cycle where div_cnt wraps with idx=4, the block SHALL load all five inputs into the snapshot if hold=0, and assert frame_tick for that cycle.
REQ-018 If hold=1 on that cycle, the snapshot SHALL be kept, and frame_tick SHALL still pulse.
REQ-019 hold SHALL be sampled only on the frame-wrap cycle, so that a frame never shows a mix of old and new digits.
REQ-020 All outputs SHALL be registered, giving 1-cycle latency from div_cnt/idx to seg_out/dp/an.
REQ-021 When div_cnt < BLANK, an SHALL be 5'b11111; otherwise an SHALL have only bit idx low.
REQ-022 The decode SHALL be: 0->1000000, 1->1111001, 2->0100100, 3->0110000, 4->0011001, 5->0010010, 6->0000010, 7->1111000, 8->0000000, 9->0010000.
REQ-023 A snapshot digit value of 10..15 SHALL display dash 0111111.
REQ-024 Leading-zero blank: when idx=4 and the snapshot seg_dec is 0, seg_out SHALL be 1111111 (the anode is still driven per REQ-021).
REQ-025 dp SHALL be 0 only when idx=3 and the anode is active; otherwise 1.
REQ-026 seg_out SHALL reflect the digit of the current idx throughout the slot, including during the blank period.
REQ-027 Input changes outside the frame-wrap cycle SHALL have no effect on the outputs.

Reset
REQ-028 While rst=0: div_cnt=0, idx=0, snapshot all 0, an=11111, seg_out=1111111, dp=1, frame_tick=0.
REQ-029 Reset assertion mid-slot SHALL force the REQ-028 values immediately, without waiting for clk.
REQ-030 After release, the first frame SHALL display snapshot zeros: digits 0-3 show 1000000, digit 4 is blanked; the first input load occurs at the end of that first frame.

Verification (REFRESH_DIV=4, BLANK=1)
REQ-031 Reset, release, run 20 cycles, inputs 0 -> an cycles through 11110,11101,11011,10111,01111, each low for 3 of every 4 cycles and 11111 for 1; digit 4 shows 1111111; dp=0 only in slot 3.
REQ-032 Inputs {seg_dec,seg,cent,dec,count}={5,9,3,7,1}, hold=0, wait one frame wrap -> frame_tick pulses once; next frame slots show 1111001, 1111000, 0110000, 0010000 (dp=0), 0010010.
REQ-033 Frame loaded, then hold=1 before the next wrap, then inputs changed to all 2 -> displayed values unchanged for two frames; release hold -> 0100100 appears in the following frame.
REQ-034 count=4'hC loaded -> slot 0 shows 0111111.
REQ-035 Assert rst=0 asynchronously mid-slot 2 -> outputs reach REQ-028 values before the next clk edge; after release, scanning restarts at slot 0.
REQ-036 Change inputs on every cycle except the wrap cycle -> the display shows only the values present on the wrap cycle.
